vcdl_phase_scanner: RTL
=======================

Name: vcdl_phase_scanner

Overview:
- Receive-side companion to the RITC VCDL generator.
- Sweeps the VCDL loopback IDELAY tap (0..31) by driving the generator's delay value and delay-load strobe.
- At each tap, samples the delayed VCDL sync copy a fixed number of CLK cycles after each sync pulse and records hit counts.
- Reports the first tap at which the sampled level flips; software uses this to centre VCDL phase.

Parameters:
- SAMPLE_LOG2, 4, log2 of samples taken per tap (16 samples).
- SAMPLE_OFFSET, 1, CLK cycles from sync_i to the sampling point (1..15).
- SETTLE_CYCLES, 16, idle CLK cycles after each delay load before arming (1..255).
- TIMEOUT_CYCLES, 4096, watchdog limit in CLK cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle scan request.
- idelayctrl_rdy_i  in  1  IDELAYCTRL ready from the generator.
- sync_i  in  1  same sync pulse the generator forwards to VCDL.
- vcdl_sync_i  in  1  delayed VCDL copy from the generator IDELAY.
- delay_o  out  5  tap value to the generator delay input.
- load_delay_o  out  1  one-cycle load strobe to the generator.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan completion.
- edge_valid_o  out  1  a transition was found in the last scan.
- edge_tap_o  out  5  first tap whose majority level differs from tap 0.
- tap_addr_i  in  5  readback address.
- tap_hits_o  out  SAMPLE_LOG2+1  hit count of the addressed tap; registered, 1-cycle read latency.
- timeout_o  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst_i high at posedge): state=IDLE. delay_o=0, load_delay_o=0, busy_o=0, done_o=0, edge_valid_o=0, edge_tap_o=0, timeout_o=0. Hit memory is not cleared; tap_hits_o is undefined until the first scan completes. Reset mid-scan aborts immediately and issues no load strobe.
- start_i is ignored unless state=IDLE.
- States:
  - IDLE: on start_i, busy_o=1, tap=0, go to WAIT_RDY.
  - WAIT_RDY: hold until idelayctrl_rdy_i=1, then go to LOAD.
  - LOAD: one cycle; delay_o=tap and load_delay_o=1 in the same cycle. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to ARM with hits=0 and nsamp=0.
  - ARM: wait for sync_i=1. A sync_i seen in any other state is ignored. Go to OFFSET.
  - OFFSET: count SAMPLE_OFFSET cycles. On the last cycle, capture vcdl_sync_i, do hits+=captured, nsamp+=1. If nsamp reaches 2^SAMPLE_LOG2, go to STORE; otherwise go to ARM.
  - STORE: write hits to mem[tap]. majority = hits > 2^(SAMPLE_LOG2-1); an exact half counts as 0.
    - At tap 0, latch majority as ref.
    - At any later tap, if majority != ref and edge_valid is not yet set, set edge_valid and edge_tap=tap.
    - If tap==31, go to FINAL; otherwise tap+=1 and go to LOAD.
  - FINAL: one cycle with delay_o = edge_valid ? edge_tap : 0 and load_delay_o=1. Update edge_valid_o and edge_tap_o, pulse done_o, clear busy_o, return to IDLE.
- edge_valid_o and edge_tap_o hold until the next FINAL or reset. They are not cleared at start, only overwritten at FINAL.
- Counters saturate; they never wrap. hits is SAMPLE_LOG2+1 bits wide, so 16/16 is representable.
- A sync_i pulse arriving back-to-back with OFFSET exit is missed by design; the next pulse is used.
- Scan duration = 32 × (2 + SETTLE_CYCLES + 2^SAMPLE_LOG2 × (sync period)) + 1 cycles, approximately.

Optional Feature:
- VCDL_SCAN_TIMEOUT_EN
- Defined: a watchdog counter resets on every ARM entry.
  - If it reaches TIMEOUT_CYCLES while in ARM or WAIT_RDY, set timeout_o (sticky until the next start_i or reset).
  - Go to FINAL with edge_valid forced 0, giving delay_o=0 and a done_o pulse.
- Undefined: no watchdog. ARM and WAIT_RDY wait indefinitely; timeout_o is constant 0.

Test Plan:
- Model vcdl_sync_i = sync_i delayed by one cycle plus 78 ps/tap, with the flip at tap 13; sync every 8 cycles; start_i.
  - Expect 32 load_delay_o strobes with delay_o 0..31, then a final strobe with delay_o=13.
  - Expect done_o pulse, edge_valid_o=1, edge_tap_o=13.
  - Readback: tap_hits_o at addr 12 = 0, at addr 13 = 16.
- vcdl_sync_i stuck 1 -> all tap_hits_o=16, edge_valid_o=0, edge_tap_o=0, final delay_o=0.
- vcdl_sync_i random 50% at tap 5, exactly 8/16 hits -> majority 0 at tap 5; the edge is reported at the first tap with ≥9 hits.
- idelayctrl_rdy_i low for 100 cycles after start_i -> no load_delay_o until ready rises; busy_o=1 throughout.
- Assert rst_i at tap 7 during OFFSET -> next cycle busy_o=0, load_delay_o=0, delay_o=0; start_i pulses while busy are ignored.
- With VCDL_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=64, stop sync_i at tap 3 -> timeout_o=1 after 64 cycles in ARM, done_o pulse, edge_valid_o=0, final delay_o=0.

Source files
------------

// File: rtl/vcdl_phase_scanner.sv
// VCDL phase scanner: sweeps the loopback IDELAY tap, counts sampled sync hits per tap
// and reports the first tap whose majority level differs from tap 0. Optional watchdog: VCDL_SCAN_TIMEOUT_EN.
module vcdl_phase_scanner #(
   parameter int SAMPLE_LOG2    = 4,
   parameter int SAMPLE_OFFSET  = 1,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   CLK,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   idelayctrl_rdy_i,
   input  logic                   sync_i,
   input  logic                   vcdl_sync_i,
   output logic [4:0]             delay_o,
   output logic                   load_delay_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   edge_valid_o,
   output logic [4:0]             edge_tap_o,
   input  logic [4:0]             tap_addr_i,
   output logic [SAMPLE_LOG2:0]   tap_hits_o,
   output logic                   timeout_o
);

   // state    | meaning
   // IDLE     | waiting for start_i
   // WAIT_RDY | waiting for IDELAYCTRL ready
   // LOAD     | strobe current tap into the generator
   // SETTLE   | let the IDELAY settle after a load
   // ARM      | waiting for a sync pulse
   // OFFSET   | counting to the sampling point, then sample
   // STORE    | write hit count, update reference/edge
   // FINAL    | load the found edge tap (or 0), finish
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_RDY = 3'd1;
   localparam logic [2:0] ST_LOAD     = 3'd2;
   localparam logic [2:0] ST_SETTLE   = 3'd3;
   localparam logic [2:0] ST_ARM      = 3'd4;
   localparam logic [2:0] ST_OFFSET   = 3'd5;
   localparam logic [2:0] ST_STORE    = 3'd6;
   localparam logic [2:0] ST_FINAL    = 3'd7;

   localparam int HW = SAMPLE_LOG2 + 1;
   localparam logic [HW-1:0] NSAMP_FULL = HW'(1 << SAMPLE_LOG2);
   localparam logic [HW-1:0] HALF       = HW'(1 << (SAMPLE_LOG2 - 1));
   localparam logic [HW-1:0] CNT_MAX    = '1;

   logic [2:0]    state_q, state_d;
   logic [4:0]    tap_q, tap_d;
   logic [7:0]    settle_q, settle_d;
   logic [3:0]    off_q, off_d;
   logic [HW-1:0] hits_q, hits_d;
   logic [HW-1:0] nsamp_q, nsamp_d;
   logic [HW-1:0] nsamp_inc;
   logic          ref_q, ref_d;
   logic          scan_valid_q, scan_valid_d;
   logic [4:0]    scan_tap_q, scan_tap_d;
   logic          edge_valid_q, edge_valid_d;
   logic [4:0]    edge_tap_q, edge_tap_d;
   logic          done_q, done_d;
   logic          majority;
   logic [HW-1:0] mem [0:31];
   logic [HW-1:0] tap_hits_q;

`ifdef VCDL_SCAN_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] wdog_q, wdog_d;
   logic           timeout_q, timeout_d;
   logic           wait_state;
   assign wait_state = (state_q == ST_ARM) || (state_q == ST_WAIT_RDY);
`endif

   assign majority  = hits_q > HALF;
   assign nsamp_inc = (nsamp_q == CNT_MAX) ? nsamp_q : nsamp_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      settle_d     = settle_q;
      off_d        = off_q;
      hits_d       = hits_q;
      nsamp_d      = nsamp_q;
      ref_d        = ref_q;
      scan_valid_d = scan_valid_q;
      scan_tap_d   = scan_tap_q;
      edge_valid_d = edge_valid_q;
      edge_tap_d   = edge_tap_q;
      done_d       = 1'b0;
`ifdef VCDL_SCAN_TIMEOUT_EN
      wdog_d       = wdog_q;
      timeout_d    = timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d      = ST_WAIT_RDY;
               tap_d        = 5'd0;
               ref_d        = 1'b0;
               scan_valid_d = 1'b0;
               scan_tap_d   = 5'd0;
            end
         end
         ST_WAIT_RDY: if (idelayctrl_rdy_i) state_d = ST_LOAD;
         ST_LOAD: begin
            settle_d = 8'(SETTLE_CYCLES - 1);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == 8'd0) begin
               state_d = ST_ARM;
               hits_d  = '0;
               nsamp_d = '0;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         ST_ARM: begin
            if (sync_i) begin
               off_d   = 4'(SAMPLE_OFFSET - 1);
               state_d = ST_OFFSET;
            end
         end
         ST_OFFSET: begin
            if (off_q == 4'd0) begin
               if (vcdl_sync_i && hits_q != CNT_MAX) hits_d = hits_q + 1'b1;
               nsamp_d = nsamp_inc;
               state_d = (nsamp_inc >= NSAMP_FULL) ? ST_STORE : ST_ARM;
            end else begin
               off_d = off_q - 4'd1;
            end
         end
         ST_STORE: begin
            if (tap_q == 5'd0) begin
               ref_d = majority;
            end else if (majority != ref_q && !scan_valid_q) begin
               scan_valid_d = 1'b1;
               scan_tap_d   = tap_q;
            end
            if (tap_q == 5'd31) begin
               state_d = ST_FINAL;
            end else begin
               tap_d   = tap_q + 5'd1;
               state_d = ST_LOAD;
            end
         end
         ST_FINAL: begin
            edge_valid_d = scan_valid_q;
            edge_tap_d   = scan_valid_q ? scan_tap_q : 5'd0;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef VCDL_SCAN_TIMEOUT_EN
      if (state_q == ST_IDLE && start_i) timeout_d = 1'b0;
      // Expiry only while still stuck waiting; a sync/ready on the last cycle wins.
      if (wait_state && state_d == state_q && wdog_q == '0) begin
         timeout_d    = 1'b1;
         scan_valid_d = 1'b0;
         scan_tap_d   = 5'd0;
         state_d      = ST_FINAL;
      end else if ((state_d == ST_ARM || state_d == ST_WAIT_RDY) && state_d != state_q) begin
         wdog_d = WDW'(TIMEOUT_CYCLES - 1);
      end else if (wait_state && wdog_q != '0) begin
         wdog_d = wdog_q - 1'b1;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         tap_q        <= 5'd0;
         settle_q     <= 8'd0;
         off_q        <= 4'd0;
         hits_q       <= '0;
         nsamp_q      <= '0;
         ref_q        <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_tap_q   <= 5'd0;
         edge_valid_q <= 1'b0;
         edge_tap_q   <= 5'd0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         settle_q     <= settle_d;
         off_q        <= off_d;
         hits_q       <= hits_d;
         nsamp_q      <= nsamp_d;
         ref_q        <= ref_d;
         scan_valid_q <= scan_valid_d;
         scan_tap_q   <= scan_tap_d;
         edge_valid_q <= edge_valid_d;
         edge_tap_q   <= edge_tap_d;
         done_q       <= done_d;
      end
   end

`ifdef VCDL_SCAN_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (rst_i) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   // Hit memory is deliberately not reset.
   always_ff @(posedge CLK) begin
      if (state_q == ST_STORE) mem[tap_q] <= hits_q;
      tap_hits_q <= mem[tap_addr_i];
   end

   assign load_delay_o = (state_q == ST_LOAD) || (state_q == ST_FINAL);
   assign delay_o      = (state_q == ST_LOAD)                   ? tap_q      :
                         (state_q == ST_FINAL && scan_valid_q)  ? scan_tap_q : 5'd0;
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
   assign edge_valid_o = edge_valid_q;
   assign edge_tap_o   = edge_tap_q;
   assign tap_hits_o   = tap_hits_q;

endmodule
